// File: rtl/silife_max7219_pkg.sv
// Shared definitions for the MAX7219 link (receiver and transmitter).
// Holds the register address map, the frame length and the SPI state type.
package silife_max7219_pkg;

  localparam logic [3:0] REG_NOOP       = 4'h0;
  localparam logic [3:0] REG_DIGIT0     = 4'h1;
  localparam logic [3:0] REG_DECODE     = 4'h9;
  localparam logic [3:0] REG_INTENSITY  = 4'hA;
  localparam logic [3:0] REG_SCAN_LIMIT = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN   = 4'hC;
  localparam logic [3:0] REG_TEST       = 4'hF;

  localparam int FRAME_BITS = 16;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

endpackage

// File: rtl/silife_sync_edge.sv
// N-stage synchroniser for an asynchronous input, with one extra register
// used for edge detection.
// Ports:
//   clk, reset (active-low async)
//   d    : asynchronous input
//   q    : synchronised level, delayed to line up with the edge pulses
//   rise : one-cycle pulse on a synchronised 0->1 transition
//   fall : one-cycle pulse on a synchronised 1->0 transition
module silife_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              last;

  // Edge pulses are registered so that q (taken from the edge register) and
  // rise/fall refer to the same sample: a data line passed through this block
  // is valid together with the clock-line pulse of a second instance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= '0;
      last <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      last <= sync[STAGES-1];
      rise <= sync[STAGES-1] & ~last;
      fall <= ~sync[STAGES-1] & last;
    end
  end

  assign q = last;

endmodule

// File: rtl/silife_max7219_rx.sv
// SPI receiver emulating a single MAX7219 LED driver.
// Deserialises CS/SCK/MOSI frames, decodes register writes into an 8x8 row
// framebuffer plus control registers, and passes shifted-out bits on DOUT
// for daisy-chaining.
// Ports:
//   clk, reset (active-low async)
//   i_cs, i_sck, i_mosi : SPI inputs, asynchronous to clk
//   o_dout              : daisy-chain output (old MSB of the shift register)
//   o_rows              : framebuffer, o_rows[r*8 +: 8] = digit register r+1
//   o_decode_mode, o_intensity, o_scan_limit, o_shutdown_n, o_display_test
//   o_wr_valid/o_wr_addr/o_wr_data : one-cycle report of an accepted write
//   o_frame_error       : one-cycle pulse when a frame is discarded
module silife_max7219_rx
  import silife_max7219_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ROWS        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_cs,
  input  logic              i_sck,
  input  logic              i_mosi,
  output logic              o_dout,
  output logic [ROWS*8-1:0] o_rows,
  output logic [7:0]        o_decode_mode,
  output logic [3:0]        o_intensity,
  output logic [2:0]        o_scan_limit,
  output logic              o_shutdown_n,
  output logic              o_display_test,
  output logic              o_wr_valid,
  output logic [3:0]        o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic              o_frame_error
);

  logic cs_q, cs_rise, cs_fall;
  logic sck_q, sck_rise, sck_fall;
  logic mosi, mosi_rise, mosi_fall;
  logic unused_sync;

  silife_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .reset(reset), .d(i_cs),
    .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );

  silife_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(clk), .reset(reset), .d(i_sck),
    .q(sck_q), .rise(sck_rise), .fall(sck_fall)
  );

  silife_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .reset(reset), .d(i_mosi),
    .q(mosi), .rise(mosi_rise), .fall(mosi_fall)
  );

  // Only the CS edges, the SCK rising edge and the MOSI level are used.
  assign unused_sync = ^{cs_q, sck_q, sck_fall, mosi_rise, mosi_fall};

  state_t                state;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [3:0]            bit_cnt;
  logic                  any_bits;

  logic [3:0] frame_addr;
  logic [7:0] frame_data;
  logic       wr_accept;

  assign frame_addr = shift_reg[11:8];
  assign frame_data = shift_reg[7:0];
  // 0x0 is a no-op and 0xD/0xE do not exist on the MAX7219.
  assign wr_accept  = (frame_addr != REG_NOOP) && (frame_addr != 4'hD) &&
                      (frame_addr != 4'hE);

  // A CS edge takes priority over a coincident SCK edge, so the SCK edge that
  // arrives together with CS falling is never shifted. bit_cnt wraps every
  // 16 bits, so a zero count on CS rising means a whole number of frames and
  // the shift register then holds the last 16 bits received.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      shift_reg      <= '0;
      bit_cnt        <= '0;
      any_bits       <= 1'b0;
      o_dout         <= 1'b0;
      o_rows         <= '0;
      o_decode_mode  <= '0;
      o_intensity    <= '0;
      o_scan_limit   <= '0;
      o_shutdown_n   <= 1'b0;
      o_display_test <= 1'b0;
      o_wr_valid     <= 1'b0;
      o_wr_addr      <= '0;
      o_wr_data      <= '0;
      o_frame_error  <= 1'b0;
    end else begin
      o_wr_valid    <= 1'b0;
      o_frame_error <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt  <= '0;
          any_bits <= 1'b0;
          if (cs_fall) begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state <= IDLE;
            if (any_bits) begin
              if (bit_cnt != 4'd0) begin
                o_frame_error <= 1'b1;
              end else begin
                if (wr_accept) begin
                  o_wr_valid <= 1'b1;
                  o_wr_addr  <= frame_addr;
                  o_wr_data  <= frame_data;
                end
                case (frame_addr)
                  REG_DECODE:     o_decode_mode  <= frame_data;
                  REG_INTENSITY:  o_intensity    <= frame_data[3:0];
                  REG_SCAN_LIMIT: o_scan_limit   <= frame_data[2:0];
                  REG_SHUTDOWN:   o_shutdown_n   <= frame_data[0];
                  REG_TEST:       o_display_test <= frame_data[0];
                  default: begin
                    for (int r = 0; r < ROWS; r++) begin
                      if (frame_addr == REG_DIGIT0 + 4'(r)) begin
                        o_rows[r*8 +: 8] <= frame_data;
                      end
                    end
                  end
                endcase
              end
            end
          end else if (sck_rise) begin
            shift_reg <= {shift_reg[FRAME_BITS-2:0], mosi};
            bit_cnt   <= bit_cnt + 4'd1;
            any_bits  <= 1'b1;
            o_dout    <= shift_reg[FRAME_BITS-1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_silife_max7219_rx.sv
// Self-checking bench for silife_max7219_rx: directed frames from the test
// plan followed by random frames, compared against a register-level model.
module tb_silife_max7219_rx;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_cs = 1'b1;
  logic        i_sck = 1'b0;
  logic        i_mosi = 1'b0;
  logic        o_dout;
  logic [63:0] o_rows;
  logic [7:0]  o_decode_mode;
  logic [3:0]  o_intensity;
  logic [2:0]  o_scan_limit;
  logic        o_shutdown_n;
  logic        o_display_test;
  logic        o_wr_valid;
  logic [3:0]  o_wr_addr;
  logic [7:0]  o_wr_data;
  logic        o_frame_error;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  silife_max7219_rx #(.SYNC_STAGES(SYNC_STAGES), .ROWS(8)) dut (
    .clk(clk), .reset(reset), .i_cs(i_cs), .i_sck(i_sck), .i_mosi(i_mosi),
    .o_dout(o_dout), .o_rows(o_rows), .o_decode_mode(o_decode_mode),
    .o_intensity(o_intensity), .o_scan_limit(o_scan_limit),
    .o_shutdown_n(o_shutdown_n), .o_display_test(o_display_test),
    .o_wr_valid(o_wr_valid), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_frame_error(o_frame_error)
  );

  // Reference model: register contents plus the last 16 bits shifted in.
  logic [7:0]  m_rows [8];
  logic [7:0]  m_decode;
  logic [3:0]  m_intensity;
  logic [2:0]  m_scan;
  logic        m_shdn;
  logic        m_test;
  bit          m_stream[$];
  logic [63:0] last_dout;

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 8; r++) m_rows[r] = 8'h00;
    m_decode = 8'h00;
    m_intensity = 4'h0;
    m_scan = 3'h0;
    m_shdn = 1'b0;
    m_test = 1'b0;
    m_stream.delete();
    repeat (16) m_stream.push_back(1'b0);
  endtask

  task automatic check_state();
    logic [63:0] packed_rows;
    for (int r = 0; r < 8; r++) packed_rows[r*8 +: 8] = m_rows[r];
    checkOutput("rows", o_rows, packed_rows);
    checkOutput("decode_mode", 64'(o_decode_mode), 64'(m_decode));
    checkOutput("intensity", 64'(o_intensity), 64'(m_intensity));
    checkOutput("scan_limit", 64'(o_scan_limit), 64'(m_scan));
    checkOutput("shutdown_n", 64'(o_shutdown_n), 64'(m_shdn));
    checkOutput("display_test", 64'(o_display_test), 64'(m_test));
  endtask

  task automatic shift_bits(input logic [63:0] bits, input int n,
                            output logic [63:0] dout_obs);
    dout_obs = '0;
    for (int i = 0; i < n; i++) begin
      i_mosi = bits[n-1-i];
      repeat (HALF) @(negedge clk);
      i_sck = 1'b1;
      repeat (HALF) @(negedge clk);
      dout_obs = {dout_obs[62:0], o_dout};
      i_sck = 1'b0;
    end
  endtask

  task automatic observe_latch(output int pulses, output int first,
                               output logic [3:0] addr, output logic [7:0] data,
                               output int errs);
    pulses = 0;
    first = 0;
    addr = '0;
    data = '0;
    errs = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (o_wr_valid) begin
        pulses++;
        if (first == 0) first = k;
        addr = o_wr_addr;
        data = o_wr_data;
      end
      if (o_frame_error) errs++;
    end
  endtask

  // Sends one complete CS-framed transfer of n bits (MSB first) and checks it.
  task automatic applyStimulus(input logic [63:0] bits, input int n);
    logic [63:0] exp_dout, dout_obs;
    logic [15:0] word;
    logic [3:0]  e_addr, o_addr;
    logic [7:0]  e_data, o_data;
    int          e_valid, e_err, pulses, first, errs;

    exp_dout = '0;
    for (int i = 0; i < n; i++) begin
      exp_dout = {exp_dout[62:0], m_stream[0]};
      m_stream.push_back(bits[n-1-i]);
      void'(m_stream.pop_front());
    end
    word = bits[15:0];
    e_addr = word[11:8];
    e_data = word[7:0];
    e_valid = 0;
    e_err = 0;
    if (n > 0 && (n % 16) != 0) begin
      e_err = 1;
    end else if (n > 0) begin
      e_valid = (e_addr >= 4'h1 && e_addr <= 4'hC) || e_addr == 4'hF ? 1 : 0;
      if (e_addr >= 4'h1 && e_addr <= 4'h8) m_rows[e_addr - 4'h1] = e_data;
      if (e_addr == 4'h9) m_decode = e_data;
      if (e_addr == 4'hA) m_intensity = e_data[3:0];
      if (e_addr == 4'hB) m_scan = e_data[2:0];
      if (e_addr == 4'hC) m_shdn = e_data[0];
      if (e_addr == 4'hF) m_test = e_data[0];
    end

    i_cs = 1'b0;
    repeat (HALF) @(negedge clk);
    shift_bits(bits, n, dout_obs);
    repeat (HALF) @(negedge clk);
    i_cs = 1'b1;
    observe_latch(pulses, first, o_addr, o_data, errs);
    last_dout = dout_obs;

    checkOutput("wr_pulses", 64'(pulses), 64'(e_valid));
    if (e_valid != 0) begin
      checkOutput("wr_latency", 64'(first), 64'(SYNC_STAGES + 2));
      checkOutput("wr_addr", 64'(o_addr), 64'(e_addr));
      checkOutput("wr_data", 64'(o_data), 64'(e_data));
    end
    checkOutput("frame_error", 64'(errs), 64'(e_err));
    if (n > 0) checkOutput("dout_bits", dout_obs, exp_dout);
    check_state();
  endtask

  initial begin
    logic [63:0] junk;
    int          pulses, first, errs;
    logic [3:0]  a;
    logic [7:0]  d;
    int          n;

    model_reset();
    last_dout = '0;

    // Reset held with random pin activity.
    for (int i = 0; i < 5; i++) begin
      i_cs = 1'($urandom);
      i_sck = 1'($urandom);
      i_mosi = 1'($urandom);
      @(negedge clk);
      check_state();
      checkOutput("rst_dout", 64'(o_dout), 64'd0);
      checkOutput("rst_wr_valid", 64'(o_wr_valid), 64'd0);
    end
    i_cs = 1'b1;
    i_sck = 1'b0;
    i_mosi = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check_state();
    checkOutput("idle_wr_valid", 64'(o_wr_valid), 64'd0);

    // Digit and control writes.
    applyStimulus(64'h01A5, 16);
    applyStimulus(64'h083C, 16);
    applyStimulus(64'h0A07, 16);
    applyStimulus(64'h0B07, 16);
    applyStimulus(64'h0C01, 16);
    applyStimulus(64'h0F01, 16);
    applyStimulus(64'hF0FF, 16);
    applyStimulus(64'h0D55, 16);

    // Bad frames: 15 bits, then an empty CS pulse.
    applyStimulus(64'h0942, 15);
    applyStimulus(64'h0, 0);

    // Daisy chain: only the last 16 bits latch, the first 16 leave on DOUT.
    applyStimulus(64'h0A03_0155, 32);
    checkOutput("daisy_tail", 64'(last_dout[15:0]), 64'h0A03);

    // Reset in the middle of a frame, released while CS is still low.
    i_cs = 1'b0;
    repeat (HALF) @(negedge clk);
    shift_bits(64'h0C, 8, junk);
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_state();
    reset = 1'b1;
    shift_bits(64'h01, 8, junk);
    repeat (HALF) @(negedge clk);
    i_cs = 1'b1;
    observe_latch(pulses, first, a, d, errs);
    checkOutput("midrst_pulses", 64'(pulses), 64'd0);
    checkOutput("midrst_error", 64'(errs), 64'd0);
    check_state();
    applyStimulus(64'h0211, 16);

    // Random frames of assorted lengths.
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 9))
        6:       n = 0;
        7:       n = $urandom_range(1, 15);
        8:       n = $urandom_range(17, 31);
        5:       n = 32;
        9:       n = 48;
        default: n = 16;
      endcase
      applyStimulus({$urandom, $urandom}, n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
